// File: rtl/operand_select_unit_pkg.sv
// operand_select_unit_pkg: shared select codes, scoreboard slot type and match helper
package operand_select_unit_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] SEL_RF     = 3'b000;
  localparam logic [2:0] SEL_EXMEM  = 3'b001;
  localparam logic [2:0] SEL_MEMWB  = 3'b010;
  localparam logic [2:0] SEL_WBHOLD = 3'b011;
  localparam logic [2:0] SEL_IMM    = 3'b100;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;
  // r0 is hard-wired zero, so a write to it never produces a forwardable value
  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.dest == r) && (r != '0);
  endfunction
endpackage

// File: rtl/operand_select_unit_match_chain.sv
// operand_match_chain: youngest-first forwarding priority for one ALU operand
module operand_match_chain
  import operand_select_unit_pkg::*;
(
  input  slot_t                 ex_i,
  input  slot_t                 mem_i,
  input  slot_t                 wb_i,
  input  logic [REG_ADDR_W-1:0] reg_i,
  input  logic                  use_imm_i,
  output logic [2:0]            sel_o
);
  assign sel_o = use_imm_i             ? SEL_IMM    :
                 slot_match(ex_i, reg_i)  ? SEL_EXMEM  :
                 slot_match(mem_i, reg_i) ? SEL_MEMWB  :
                 slot_match(wb_i, reg_i)  ? SEL_WBHOLD : SEL_RF;
endmodule

// File: rtl/operand_select_unit.sv
// operand_select_unit: EX operand mux selects, load-use stall and saturating stall counter
module operand_select_unit
  import operand_select_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_use_imm,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic [2:0]             sel_a,
  output logic [2:0]             sel_b,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);
  slot_t                  ex_q, mem_q, wb_q, ex_d;
  logic [2:0]             sel_a_q, sel_b_q, sel_a_d, sel_b_d, a_sel, b_sel;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   issue;

  operand_match_chain u_chain_a (
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .reg_i(id_rs), .use_imm_i(1'b0), .sel_o(a_sel)
  );
  operand_match_chain u_chain_b (
    .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .reg_i(id_rt), .use_imm_i(id_use_imm), .sel_o(b_sel)
  );

  // A load in EX has no data until MEM, so a dependent ID instruction waits one cycle
  assign stall = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.dest != '0) &&
                 ((ex_q.dest == id_rs) || (!id_use_imm && (ex_q.dest == id_rt)));
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
    sel_a_d       = issue ? a_sel : SEL_RF;
    sel_b_d       = issue ? b_sel : SEL_RF;
    stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + STALL_CNT_W'(1) : stall_count_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      sel_a_q       <= SEL_RF;
      sel_b_q       <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      sel_a_q       <= sel_a_d;
      sel_b_q       <= sel_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sel_a       = sel_a_q;
  assign sel_b       = sel_b_q;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_operand_select_unit.sv
// tb_operand_select_unit: directed vectors with a queued scoreboard and decoupled monitor
module tb_operand_select_unit;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        id_valid = 1'b0, id_use_imm = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
  logic [2:0]  sel_a, sel_b, sel_a_s, sel_b_s;
  logic        stall, stall_s;
  logic [15:0] stall_count;
  logic [2:0]  cnt_s;

  typedef struct {
    string      nm;
    logic       st;
    logic [2:0] a;
    logic [2:0] b;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, exp_cnt = 0;

  always #5 Clk = ~Clk;

  operand_select_unit #(.STALL_CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_imm(id_use_imm), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .sel_a(sel_a), .sel_b(sel_b),
    .stall(stall), .stall_count(stall_count)
  );

  // Narrow-counter twin on the same inputs so saturation is reachable quickly
  operand_select_unit #(.STALL_CNT_W(3)) dut_s (
    .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_imm(id_use_imm), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .sel_a(sel_a_s), .sel_b(sel_b_s),
    .stall(stall_s), .stall_count(cnt_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic imm, input logic [4:0] d, input logic rw, input logic mr,
                      input logic fl, input logic es, input logic [2:0] ea, input logic [2:0] eb);
    exp_t e;
    @(negedge Clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_imm = imm; id_dest = d;
    id_reg_write = rw; id_mem_read = mr; flush = fl;
    if (es) exp_cnt++;
    e.nm = nm; e.st = es; e.a = ea; e.b = eb; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step("nop", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic add_r3();
    step("add_r3", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic gap();
    step("gap", 1'b1, 5'd1, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic lw_r2();
    step("lw_r2", 1'b1, 5'd1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
  endtask

  // Monitor: stall is sampled mid-cycle, selects and counts just after the edge
  initial begin
    exp_t e;
    logic s_act, s_act_s;
    forever begin
      @(negedge Clk);
      #2;
      s_act = stall;
      s_act_s = stall_s;
      @(posedge Clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, "_stall"}, 32'(s_act), 32'(e.st));
        chk({e.nm, "_sel_a"}, 32'(sel_a), 32'(e.a));
        chk({e.nm, "_sel_b"}, 32'(sel_b), 32'(e.b));
        chk({e.nm, "_count"}, 32'(stall_count), 32'(e.cnt));
        chk({e.nm, "_stall_s"}, 32'(s_act_s), 32'(e.st));
        chk({e.nm, "_sel_a_s"}, 32'(sel_a_s), 32'(e.a));
        chk({e.nm, "_sel_b_s"}, 32'(sel_b_s), 32'(e.b));
        chk({e.nm, "_count_s"}, 32'(cnt_s), (e.cnt > 7) ? 32'd7 : 32'(e.cnt));
      end
    end
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_sel_a", 32'(sel_a), 0);
    chk("rst_sel_b", 32'(sel_b), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(stall_count), 0);
    Reset = 1'b1;
    add_r3();
    step("sub_fwd_ex", 1'b1, 5'd3, 5'd4, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
    nops(3);
    add_r3(); gap();
    step("or_gap1", 1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010);
    nops(3);
    add_r3(); gap(); gap();
    step("or_gap2", 1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 3'b011);
    nops(3);
    add_r3(); gap(); gap(); gap();
    step("or_gap3", 1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    nops(3);
    lw_r2();
    step("use_stall", 1'b1, 5'd2, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    step("use_retry", 1'b1, 5'd2, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
    nops(3);
    step("wr_r0", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("rd_r0", 1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    nops(3);
    step("lw_r0", 1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
    step("rd_r0_nostall", 1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    nops(3);
    step("add_r9", 1'b1, 5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("imm_rt_hit", 1'b1, 5'd9, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b100);
    nops(3);
    step("lw_r4", 1'b1, 5'd1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
    step("imm_no_stall", 1'b1, 5'd1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b100);
    nops(3);
    step("add_flushed", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    step("after_flush", 1'b1, 5'd3, 5'd3, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    nops(3);
    lw_r2();
    step("flush_stall", 1'b1, 5'd2, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);
    step("after_fs", 1'b1, 5'd2, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010);
    nops(3);
    for (int i = 0; i < 7; i++) begin
      lw_r2();
      step("sat_stall", 1'b1, 5'd2, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
    end
    nops(3);
    lw_r2();
    @(negedge Clk);
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd1; id_use_imm = 1'b0; id_dest = 5'd7;
    id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
    #2;
    chk("pre_rst_stall", 32'(stall), 1);
    chk("pre_rst_sel_b", 32'(sel_b), 32'(3'b100));
    Reset = 1'b0;
    #1;
    chk("mid_rst_sel_a", 32'(sel_a), 0);
    chk("mid_rst_sel_b", 32'(sel_b), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_count", 32'(stall_count), 0);
    chk("mid_rst_count_s", 32'(cnt_s), 0);
    exp_cnt = 0;
    @(negedge Clk);
    id_valid = 1'b0;
    Reset = 1'b1;
    step("post_rst", 1'b1, 5'd2, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    repeat (3) @(posedge Clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_select_unit.md
Name: operand_select_unit

Overview:
- Generates the 3-bit select codes that drive the ALU-operand 5-to-1 muxes in the EX stage of the pipelined datapath. It is the control end of those muxes.
- Tracks in-flight register writes through the EX, MEM and WB slots, resolves forwarding priority and detects load-use hazards.
- Issues a one-cycle stall when a load-use hazard is found, and counts stalls for performance reporting.

Parameters:
- REG_ADDR_W, 5, register-specifier width
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_ADDR_W  source A register
- id_rt  input  REG_ADDR_W  source B register
- id_use_imm  input  1  operand B comes from the immediate
- id_dest  input  REG_ADDR_W  destination register
- id_reg_write  input  1  instruction writes the register file
- id_mem_read  input  1  instruction is a load
- flush  input  1  squash the instruction entering EX (taken branch)
- sel_a  output  3  EX-stage mux select, operand A
- sel_b  output  3  EX-stage mux select, operand B
- stall  output  1  hold PC and IF/ID; combinational
- stall_count  output  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding, shared by both muxes:
  - 000 register-file value
  - 001 EX/MEM ALU result
  - 010 MEM/WB result
  - 011 WB-hold register (one cycle past writeback)
  - 100 immediate
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, dest, reg_write, mem_read}. Slots reset to all-zero, which is a bubble.
- Slot advance on every rising Clk:
  - WB <= MEM and MEM <= EX, always.
  - EX <= ID fields when id_valid && !stall && !flush; otherwise EX <= bubble.
- Match(slot, r) = slot.valid && slot.reg_write && slot.dest == r && r != 0.
- Operand A select, computed combinationally in ID, priority youngest first:
  - Match(EX, id_rs) -> 001
  - else Match(MEM, id_rs) -> 010
  - else Match(WB, id_rs) -> 011
  - else 000
- Operand B select: id_use_imm forces 100; otherwise the same priority chain is applied to id_rt.
- Stall condition: stall = id_valid && EX.valid && EX.mem_read && EX.reg_write && EX.dest != 0 && (EX.dest == id_rs || (!id_use_imm && EX.dest == id_rt)).
- Registering selects:
  - sel_a and sel_b are registered, so latency is 1 cycle: selects computed in ID appear during that instruction's EX cycle.
  - On stall, flush or !id_valid, both register to 000.
- Stall duration: exactly 1 cycle per load-use, because the load moves to MEM on the next edge. The retried ID then matches in MEM and selects 010.
- stall_count: increments on each rising Clk where stall = 1, and saturates at all-ones with no wrap.
- flush and stall in the same cycle: flush wins for the EX slot (bubble either way). stall is still asserted and still counted.
- Reset, asserted at any time including mid-operation:
  - Immediately clears all slots, sel_a/sel_b to 000 and stall_count to 0.
  - stall goes 0 because every slot is invalid.
- Register 0 never forwards and never causes a stall.

Decomposition:
- Shared package holds the select-code constants (SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_WBHOLD, SEL_IMM), the scoreboard-slot struct and REG_ADDR_W.
- One natural sub-module: operand_match_chain, a combinational priority chain returning the 3-bit select for one operand. It is instantiated twice (A and B).
- Scoreboard, stall logic and counter stay in the top.

Test Plan:
- Reset low mid-stream with non-zero slots -> sel_a = sel_b = 000, stall = 0, stall_count = 0 immediately, without waiting for Clk.
- add r3 issued, then sub r5,r3,r4 on the next cycle -> sub's EX cycle shows sel_a = 001, sel_b = 000.
- add r3, one unrelated instruction, then or r6,r3,r3 -> sel_a = sel_b = 010; with two gap instructions -> 011; with three -> 000.
- lw r2 followed by add r7,r2,r1 -> stall = 1 for exactly one cycle and stall_count goes 0->1; the add's EX cycle shows sel_a = 010.
- Writer to r0, then a reader of r0 -> no stall, sel = 000. Reader with id_use_imm = 1 -> sel_b = 100 even when rt matches.
- flush asserted with a producer in ID -> next consumer shows no match (sel = 000). Force 65,535 stalls -> stall_count holds at 16'hFFFF on the next stall.
